// File: rtl/aibcr3aux_osc_pkg.sv
// aibcr3aux_osc_pkg: shared types and widths for the aux oscillator measurement sequencer
package aibcr3aux_osc_pkg;
  typedef enum logic [2:0] {IDLE, CLR, WIN, SETTLE, CAPT, DONE} state_t;
  localparam int CNT_W = 6;
  localparam int SUM_W = 9;
  localparam int MAX_MEAS_LOG2 = 3;
endpackage

// File: rtl/aibcr3aux_osc_meas_acc.sv
// aibcr3aux_osc_meas_acc: accumulates captured counts, averages, compares thresholds, tracks saturation
module aibcr3aux_osc_meas_acc
  import aibcr3aux_osc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             capt,
  input  logic             fin,
  input  logic [CNT_W-1:0] cnt_in,
  input  logic [1:0]       n_log2,
  input  logic [CNT_W-1:0] lo_thr,
  input  logic [CNT_W-1:0] hi_thr,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] avg,
  output logic             too_slow,
  output logic             too_fast,
  output logic             sat
);
  logic [SUM_W-1:0] acc;
  logic             sat_s;
  logic [CNT_W-1:0] avg_n;
  assign avg_n = CNT_W'(acc >> n_log2);
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      sat_s    <= 1'b0;
      sum      <= '0;
      avg      <= '0;
      too_slow <= 1'b0;
      too_fast <= 1'b0;
      sat      <= 1'b0;
    end else begin
      if (clr) begin
        acc   <= '0;
        sat_s <= 1'b0;
      end else if (capt) begin
        acc   <= acc + SUM_W'(cnt_in);
        sat_s <= sat_s | (&cnt_in);
      end
      if (fin) begin
        sum      <= acc;
        avg      <= avg_n;
        too_slow <= avg_n < lo_thr;
        too_fast <= avg_n > hi_thr;
        sat      <= sat_s;
      end
    end
  end
endmodule

// File: rtl/aibcr3aux_osc_meas_ctrl.sv
// aibcr3aux_osc_meas_ctrl: sequences clear/gate/settle/capture of the aux oscillator ripple counter
module aibcr3aux_osc_meas_ctrl
  import aibcr3aux_osc_pkg::*;
#(
  parameter int WIN_W      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int CLR_CYC    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIN_W-1:0] win_len,
  input  logic [1:0]       num_log2,
  input  logic             div2_sel,
  input  logic [CNT_W-1:0] lo_thr,
  input  logic [CNT_W-1:0] hi_thr,
  input  logic [CNT_W-1:0] cnt_in,
  output logic             cntr_en,
  output logic             cntr_reset_n,
  output logic [2:0]       cntr_sel,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] avg,
  output logic             too_slow,
  output logic             too_fast,
  output logic             sat
);
  state_t                   state;
  logic [WIN_W-1:0]         tmr;
  logic [WIN_W-1:0]         win_l;
  logic [1:0]               nl;
  logic                     div2_l;
  logic [MAX_MEAS_LOG2-1:0] idx;
  logic [MAX_MEAS_LOG2-1:0] idx_max;
  logic                     go;
  logic                     kill;
  logic                     timed;
  logic                     tmr_end;
  assign idx_max = MAX_MEAS_LOG2'((4'd1 << nl) - 4'd1);
  assign go      = state == IDLE && start && !abort;
  assign kill    = state != IDLE && abort;
  assign timed   = state == CLR || state == WIN || state == SETTLE;
  assign tmr_end = state == CLR ? tmr == WIN_W'(CLR_CYC - 1) :
                   state == WIN ? tmr == win_l - WIN_W'(1) : tmr == WIN_W'(SETTLE_CYC - 1);
  assign cntr_en      = state == WIN;
  assign cntr_reset_n = state != IDLE && state != CLR;
  assign busy         = state != IDLE;
  assign cntr_sel     = {2'b00, div2_l};
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      tmr    <= '0;
      win_l  <= '0;
      nl     <= '0;
      div2_l <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
    end else begin
      done <= state == DONE && !abort;
      tmr  <= timed && !tmr_end && !kill ? tmr + WIN_W'(1) : '0;
      if (kill) state <= IDLE;
      else case (state)
        IDLE: if (go) begin
          state  <= CLR;
          idx    <= '0;
          win_l  <= win_len == '0 ? WIN_W'(1) : win_len;
          nl     <= num_log2;
          div2_l <= div2_sel;
        end
        CLR:    state <= tmr_end ? WIN : CLR;
        WIN:    state <= tmr_end ? SETTLE : WIN;
        SETTLE: state <= tmr_end ? CAPT : SETTLE;
        CAPT: begin
          state <= idx == idx_max ? DONE : CLR;
          idx   <= idx + MAX_MEAS_LOG2'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
  aibcr3aux_osc_meas_acc u_acc (
    .clk      (clk),
    .reset    (reset),
    .clr      (go),
    .capt     (state == CAPT && !abort),
    .fin      (state == DONE && !abort),
    .cnt_in   (cnt_in),
    .n_log2   (nl),
    .lo_thr   (lo_thr),
    .hi_thr   (hi_thr),
    .sum      (sum),
    .avg      (avg),
    .too_slow (too_slow),
    .too_fast (too_fast),
    .sat      (sat)
  );
endmodule

// File: tb/tb_aibcr3aux_osc_meas_ctrl.sv
// tb_aibcr3aux_osc_meas_ctrl: directed self-checking bench for the oscillator measurement sequencer
module tb_aibcr3aux_osc_meas_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] win_len = 8'd0;
  logic [1:0] num_log2 = 2'd0;
  logic       div2_sel = 1'b0;
  logic [5:0] lo_thr = 6'd0;
  logic [5:0] hi_thr = 6'd63;
  logic [5:0] cnt_in = 6'd0;
  logic       cntr_en;
  logic       cntr_reset_n;
  logic [2:0] cntr_sel;
  logic       busy;
  logic       done;
  logic [8:0] sum;
  logic [5:0] avg;
  logic       too_slow;
  logic       too_fast;
  logic       sat;
  int tests = 0;
  int fails = 0;
  int vals[8];
  int done_at, en_cnt, pulses, bad_len, rises, dcnt, bcnt;
  aibcr3aux_osc_meas_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .win_len      (win_len),
    .num_log2     (num_log2),
    .div2_sel     (div2_sel),
    .lo_thr       (lo_thr),
    .hi_thr       (hi_thr),
    .cnt_in       (cnt_in),
    .cntr_en      (cntr_en),
    .cntr_reset_n (cntr_reset_n),
    .cntr_sel     (cntr_sel),
    .busy         (busy),
    .done         (done),
    .sum          (sum),
    .avg          (avg),
    .too_slow     (too_slow),
    .too_fast     (too_fast),
    .sat          (sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run(input int poke, output int d_at, output int en_n, output int pls, output int bad);
    int lowlen = 0;
    int k = 0;
    logic pen = 1'b0;
    d_at = -1;
    en_n = 0;
    pls = 0;
    bad = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c < 3000; c++) begin
      @(negedge clk);
      if (c == poke) begin
        start = 1'b1;
        win_len = 8'd50;
        num_log2 = 2'd3;
        div2_sel = ~div2_sel;
      end else start = 1'b0;
      if (cntr_en) en_n++;
      if (pen && !cntr_en && k < 8) begin
        cnt_in = 6'(vals[k]);
        k++;
      end
      pen = cntr_en;
      if (!cntr_reset_n) lowlen++;
      else if (lowlen > 0) begin
        pls++;
        if (lowlen != 2) bad++;
        lowlen = 0;
      end
      if (done) begin
        d_at = c;
        break;
      end
    end
    start = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {busy, done, cntr_en, cntr_reset_n, cntr_sel}, 0);
    chk("reset_res", {sum, avg, too_slow, too_fast, sat}, 0);
    reset = 1'b0;
    win_len = 8'd10; num_log2 = 2'd0; vals[0] = 37;
    run(-1, done_at, en_cnt, pulses, bad_len);
    chk("t1_done_at", done_at, 19);
    chk("t1_en_cycles", en_cnt, 10);
    chk("t1_sum", int'(sum), 37);
    chk("t1_avg", int'(avg), 37);
    chk("t1_flags", {too_slow, too_fast, sat}, 0);
    @(negedge clk);
    chk("t1_done_pulse", {done, busy}, 0);
    num_log2 = 2'd2; vals[0] = 20; vals[1] = 21; vals[2] = 22; vals[3] = 23;
    run(-1, done_at, en_cnt, pulses, bad_len);
    chk("t2_done_at", done_at, 70);
    chk("t2_en_cycles", en_cnt, 40);
    chk("t2_rst_pulses", pulses, 4);
    chk("t2_rst_len_bad", bad_len, 0);
    chk("t2_sum", int'(sum), 86);
    chk("t2_avg", int'(avg), 21);
    chk("t2_flags", {too_slow, too_fast, sat}, 0);
    lo_thr = 6'd30; hi_thr = 6'd40; win_len = 8'd3; num_log2 = 2'd0;
    vals[0] = 29;
    run(-1, done_at, en_cnt, pulses, bad_len);
    chk("t3a_done_at", done_at, 12);
    chk("t3a_flags", {too_slow, too_fast, sat}, 3'b100);
    vals[0] = 41;
    run(-1, done_at, en_cnt, pulses, bad_len);
    chk("t3b_flags", {too_slow, too_fast, sat}, 3'b010);
    vals[0] = 63;
    run(-1, done_at, en_cnt, pulses, bad_len);
    chk("t3c_flags", {too_slow, too_fast, sat}, 3'b011);
    chk("t3c_sum", int'(sum), 63);
    lo_thr = 6'd0; hi_thr = 6'd63; win_len = 8'd10; num_log2 = 2'd2; cnt_in = 6'd5;
    rises = 0;
    dcnt = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      logic pen = 1'b0;
      for (int c = 0; c < 200 && rises < 2; c++) begin
        @(negedge clk);
        if (cntr_en && !pen) rises++;
        if (done) dcnt++;
        pen = cntr_en;
      end
    end
    chk("t4_reach_win2", rises, 2);
    abort = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("t4_abort_state", {busy, cntr_en, cntr_reset_n, done}, 0);
    chk("t4_keep_sum", int'(sum), 63);
    chk("t4_keep_avg", int'(avg), 63);
    bcnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    chk("t4_no_done", dcnt, 0);
    chk("t4_start_ignored", bcnt, 0);
    win_len = 8'd0; num_log2 = 2'd0; div2_sel = 1'b1; vals[0] = 12;
    run(2, done_at, en_cnt, pulses, bad_len);
    chk("t5_en_cycles", en_cnt, 1);
    chk("t5_done_at", done_at, 10);
    chk("t5_sum", int'(sum), 12);
    chk("t5_avg", int'(avg), 12);
    chk("t5_sel", int'(cntr_sel), 1);
    dcnt = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("t5_one_done", dcnt, 0);
    win_len = 8'd4; num_log2 = 2'd0; div2_sel = 1'b0;
    rises = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    begin
      logic pen = 1'b0;
      for (int c = 0; c < 100 && rises == 0; c++) begin
        @(negedge clk);
        if (pen && !cntr_en) rises = 1;
        pen = cntr_en;
      end
    end
    chk("t6_reach_settle", rises, 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("t6_reset_ctrl", {busy, done, cntr_en, cntr_reset_n, cntr_sel}, 0);
    chk("t6_reset_res", {sum, avg, too_slow, too_fast, sat}, 0);
    vals[0] = 9;
    run(-1, done_at, en_cnt, pulses, bad_len);
    chk("t6_done_at", done_at, 13);
    chk("t6_sum", int'(sum), 9);
    chk("t6_avg", int'(avg), 9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
